// File: rtl/bimode_pkg.sv
// bimode_pkg: shared types and helpers for the bi-mode branch predictor.
//   cnt_t        - saturating counter container (holds counters up to CNT_MAX_W bits)
//   inflight_t   - one outstanding prediction: indices, bank used, predicted direction
//   state_e      - recovery FSM states
//   choice_rst / taken_rst / ntaken_rst - counter reset constants for a given width
//   cnt_sat      - saturating increment/decrement toward a resolved outcome
package bimode_pkg;

  localparam int CNT_MAX_W = 8;
  localparam int IDX_MAX_W = 16;

  typedef logic [CNT_MAX_W-1:0] cnt_t;

  typedef struct packed {
    logic [IDX_MAX_W-1:0] choice_idx;
    logic [IDX_MAX_W-1:0] dir_idx;
    logic                 bank_sel;
    logic                 pred;
  } inflight_t;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_RECOVER = 1'b1
  } state_e;

  // Weakly not-taken: 0111..1
  function automatic cnt_t choice_rst(input int w);
    return cnt_t'((1 << (w - 1)) - 1);
  endfunction

  // Weakly taken: 1000..0
  function automatic cnt_t taken_rst(input int w);
    return cnt_t'(1 << (w - 1));
  endfunction

  function automatic cnt_t ntaken_rst(input int w);
    return cnt_t'((1 << (w - 1)) - 1);
  endfunction

  function automatic cnt_t cnt_sat(input cnt_t c, input logic up, input int w);
    cnt_t max_v;
    max_v = cnt_t'((1 << w) - 1);
    if (up) return (c >= max_v) ? c : c + cnt_t'(1);
    else    return (c == '0)    ? c : c - cnt_t'(1);
  endfunction

endpackage

// File: rtl/bimode_inflight_q.sv
// bimode_inflight_q: circular FIFO of outstanding predictions.
//   push/push_data - enqueue (ignored when full)
//   pop            - dequeue oldest (ignored when empty)
//   flush          - empty the queue; wins over push/pop in the same cycle
//   head_data      - oldest entry, valid when !empty
//   full/empty/count - occupancy status, reflecting the previous edge
module bimode_inflight_q #(
  parameter  int W     = 34,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [W-1:0]  head_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];
  assign push_ok   = push && !full;
  assign pop_ok    = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/bimode_pred_ng.sv
// bimode_pred_ng: parametrised bi-mode branch predictor with speculative
// global history, in-order resolution and mispredict recovery.
//   pred_valid/pred_ready/branch_address   - prediction request handshake
//   pred_resp_valid/prediction/pred_resp_squash - registered response, one cycle later
//   upd_valid/real_ton                     - resolve oldest in-flight branch
//   upd_mispredict/upd_err                 - registered resolve status pulses
//   inflight_cnt                           - outstanding predictions
//   total_cnt/hit_cnt                      - statistics, present only when
//                                            BIMODE_STATS_EN is defined (else 0)
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_RUN     | normal operation, accept requests while queue not full
// ST_RECOVER | one cycle after a mispredict flush, requests held off
module bimode_pred_ng
  import bimode_pkg::*;
#(
  parameter  int ADDR_W   = 64,
  parameter  int HIST_W   = 8,
  parameter  int IDX_W    = 8,
  parameter  int CNT_W    = 2,
  parameter  int INFLIGHT = 4,
  parameter  int STAT_W   = 32,
  localparam int ICW      = $clog2(INFLIGHT) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pred_valid,
  output logic              pred_ready,
  input  logic [ADDR_W-1:0] branch_address,
  output logic              pred_resp_valid,
  output logic              prediction,
  output logic              pred_resp_squash,
  input  logic              upd_valid,
  input  logic              real_ton,
  output logic              upd_mispredict,
  output logic              upd_err,
  output logic [ICW-1:0]    inflight_cnt,
  output logic [STAT_W-1:0] total_cnt,
  output logic [STAT_W-1:0] hit_cnt
);

  localparam int TBL_N = 2 ** IDX_W;
  localparam int QW    = $bits(inflight_t);

  logic [CNT_W-1:0] choice_q [TBL_N];
  logic [CNT_W-1:0] taken_q  [TBL_N];
  logic [CNT_W-1:0] ntaken_q [TBL_N];

  logic [HIST_W-1:0] spec_hist_q, spec_hist_d;
  logic [HIST_W-1:0] arch_hist_q, arch_hist_d;
  state_e            state_q, state_d;
  logic              resp_valid_q, resp_valid_d;
  logic              prediction_q, prediction_d;
  logic              squash_q, squash_d;
  logic              mispredict_q, mispredict_d;
  logic              err_q, err_d;

  logic [IDX_W-1:0] base_idx, dir_idx;
  logic [CNT_W-1:0] choice_rd, dir_rd;
  logic             bank_sel, pred_dir, accept;

  logic             q_full, q_empty, q_push, resolve, mispredict;
  logic [QW-1:0]    q_head_raw;
  inflight_t        q_head, q_push_e;
  logic [IDX_W-1:0] h_choice, h_dir;
  logic [CNT_W-1:0] sel_rd, sel_new, choice_new;
  logic             choice_upd;
  logic             unused_bits;

  // Lookup for the incoming request (pre-update tables, no bypass)
  always_comb begin
    base_idx  = branch_address[IDX_W+1:2];
    dir_idx   = base_idx ^ IDX_W'(spec_hist_q);
    choice_rd = choice_q[base_idx];
    bank_sel  = choice_rd[CNT_W-1];
    dir_rd    = bank_sel ? taken_q[dir_idx] : ntaken_q[dir_idx];
    pred_dir  = dir_rd[CNT_W-1];
  end

  assign pred_ready = (state_q == ST_RUN) && !q_full;
  assign accept     = pred_valid && pred_ready;

  // Resolution of the oldest entry
  always_comb begin
    q_head     = inflight_t'(q_head_raw);
    h_choice   = q_head.choice_idx[IDX_W-1:0];
    h_dir      = q_head.dir_idx[IDX_W-1:0];
    resolve    = upd_valid && !q_empty;
    mispredict = resolve && (real_ton != q_head.pred);
    sel_rd     = q_head.bank_sel ? taken_q[h_dir] : ntaken_q[h_dir];
    sel_new    = CNT_W'(cnt_sat(cnt_t'(sel_rd), real_ton, CNT_W));
    choice_new = CNT_W'(cnt_sat(cnt_t'(choice_q[h_choice]), real_ton, CNT_W));
    // Leave the chooser alone when the other bank was "wrong" but the
    // selected bank already got it right: that bank is doing its job.
    choice_upd = !((q_head.bank_sel != real_ton) && (sel_rd[CNT_W-1] == real_ton));
  end

  // Histories, FSM and registered outputs
  always_comb begin
    arch_hist_d  = arch_hist_q;
    spec_hist_d  = spec_hist_q;
    state_d      = state_q;
    resp_valid_d = accept;
    prediction_d = accept && pred_dir;
    squash_d     = accept && mispredict;
    mispredict_d = mispredict;
    err_d        = upd_valid && q_empty;
    q_push       = accept && !mispredict;

    if (resolve) arch_hist_d = {arch_hist_q[HIST_W-2:0], real_ton};

    if (mispredict)  spec_hist_d = arch_hist_d;
    else if (accept) spec_hist_d = {spec_hist_q[HIST_W-2:0], pred_dir};

    case (state_q)
      ST_RUN:     if (mispredict) state_d = ST_RECOVER;
      ST_RECOVER: state_d = ST_RUN;
      default:    state_d = ST_RUN;
    endcase

    q_push_e            = '0;
    q_push_e.choice_idx = IDX_MAX_W'(base_idx);
    q_push_e.dir_idx    = IDX_MAX_W'(dir_idx);
    q_push_e.bank_sel   = bank_sel;
    q_push_e.pred       = pred_dir;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spec_hist_q  <= '0;
      arch_hist_q  <= '0;
      state_q      <= ST_RUN;
      resp_valid_q <= 1'b0;
      prediction_q <= 1'b0;
      squash_q     <= 1'b0;
      mispredict_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      spec_hist_q  <= spec_hist_d;
      arch_hist_q  <= arch_hist_d;
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      prediction_q <= prediction_d;
      squash_q     <= squash_d;
      mispredict_q <= mispredict_d;
      err_q        <= err_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TBL_N; i++) begin
        choice_q[i] <= CNT_W'(choice_rst(CNT_W));
        taken_q[i]  <= CNT_W'(taken_rst(CNT_W));
        ntaken_q[i] <= CNT_W'(ntaken_rst(CNT_W));
      end
    end else if (resolve) begin
      if (q_head.bank_sel) taken_q[h_dir]  <= sel_new;
      else                 ntaken_q[h_dir] <= sel_new;
      if (choice_upd) choice_q[h_choice] <= choice_new;
    end
  end

  bimode_inflight_q #(
    .W     (QW),
    .DEPTH (INFLIGHT)
  ) u_q (
    .clk       (clk),
    .rst       (rst),
    .push      (q_push),
    .push_data (q_push_e),
    .pop       (resolve),
    .flush     (mispredict),
    .head_data (q_head_raw),
    .full      (q_full),
    .empty     (q_empty),
    .count     (inflight_cnt)
  );

  assign pred_resp_valid  = resp_valid_q;
  assign prediction       = prediction_q;
  assign pred_resp_squash = squash_q;
  assign upd_mispredict   = mispredict_q;
  assign upd_err          = err_q;

`ifdef BIMODE_STATS_EN
  logic [STAT_W-1:0] total_q, total_d;
  logic [STAT_W-1:0] hit_q, hit_d;

  always_comb begin
    total_d = total_q;
    hit_d   = hit_q;
    if (resolve && (total_q != '1))               total_d = total_q + STAT_W'(1);
    if (resolve && !mispredict && (hit_q != '1))  hit_d   = hit_q + STAT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total_q <= '0;
      hit_q   <= '0;
    end else begin
      total_q <= total_d;
      hit_q   <= hit_d;
    end
  end

  assign total_cnt = total_q;
  assign hit_cnt   = hit_q;
`else
  assign total_cnt = '0;
  assign hit_cnt   = '0;
`endif

  // Address bits outside the index and widened index fields are not used.
  assign unused_bits = ^{branch_address, q_head_raw};

endmodule

// File: tb/tb_bimode_pred_ng.sv
module tb_bimode_pred_ng;
  localparam int ADDR_W = 64, HIST_W = 8, IDX_W = 8, CNT_W = 2, INFLIGHT = 4, STAT_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              pred_valid, pred_ready;
  logic [ADDR_W-1:0] branch_address;
  logic              pred_resp_valid, prediction, pred_resp_squash;
  logic              upd_valid, real_ton;
  logic              upd_mispredict, upd_err;
  logic [2:0]        inflight_cnt;
  logic [STAT_W-1:0] total_cnt, hit_cnt;

  always #5 clk = ~clk;

  bimode_pred_ng #(
    .ADDR_W(ADDR_W), .HIST_W(HIST_W), .IDX_W(IDX_W),
    .CNT_W(CNT_W), .INFLIGHT(INFLIGHT), .STAT_W(STAT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .pred_valid(pred_valid), .pred_ready(pred_ready), .branch_address(branch_address),
    .pred_resp_valid(pred_resp_valid), .prediction(prediction),
    .pred_resp_squash(pred_resp_squash),
    .upd_valid(upd_valid), .real_ton(real_ton),
    .upd_mispredict(upd_mispredict), .upd_err(upd_err),
    .inflight_cnt(inflight_cnt), .total_cnt(total_cnt), .hit_cnt(hit_cnt)
  );

  // ---------------- behavioural model ----------------
  typedef struct { int ch; int dir; bit bank; bit pred; } ent_t;
  int   m_ch[256], m_tk[256], m_nt[256];
  int   m_spec, m_arch;
  bit   m_recover;
  ent_t m_q[$];
  longint m_total, m_hit;
  bit   e_rv, e_pred, e_sq, e_mis, e_err;

  int vectors = 0, miscompares = 0, n_cmp = 0;

  function automatic int sat(input int c, input bit up);
    if (up) return (c == 3) ? 3 : c + 1;
    return (c == 0) ? 0 : c - 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) begin
      m_ch[i] = 1; m_tk[i] = 2; m_nt[i] = 1;
    end
    m_spec = 0; m_arch = 0; m_recover = 0; m_q.delete();
    m_total = 0; m_hit = 0;
    e_rv = 0; e_pred = 0; e_sq = 0; e_mis = 0; e_err = 0;
  endtask

  task automatic model_edge();
    bit ready, acc, mis, err, bank, p;
    int base, dir, sel;
    ent_t e;
    ready = !m_recover && (m_q.size() < INFLIGHT);
    acc   = pred_valid && ready;
    base  = int'(branch_address[9:2]);
    dir   = (base ^ m_spec) & 255;
    bank  = (m_ch[base] >= 2);
    p     = bank ? (m_tk[dir] >= 2) : (m_nt[dir] >= 2);
    mis = 0; err = 0;
    if (upd_valid) begin
      if (m_q.size() == 0) err = 1;
      else begin
        e   = m_q.pop_front();
        sel = e.bank ? m_tk[e.dir] : m_nt[e.dir];
        mis = (real_ton != e.pred);
        if (!((e.bank != real_ton) && ((sel >= 2) == real_ton)))
          m_ch[e.ch] = sat(m_ch[e.ch], real_ton);
        if (e.bank) m_tk[e.dir] = sat(sel, real_ton);
        else        m_nt[e.dir] = sat(sel, real_ton);
        m_arch = ((m_arch << 1) | int'(real_ton)) & 255;
        m_total++;
        if (!mis) m_hit++;
      end
    end
    if (mis) begin
      m_q.delete(); m_spec = m_arch; m_recover = 1;
    end else begin
      m_recover = 0;
      if (acc) begin
        e.ch = base; e.dir = dir; e.bank = bank; e.pred = p;
        m_q.push_back(e);
        m_spec = ((m_spec << 1) | int'(p)) & 255;
      end
    end
    e_rv = acc; e_pred = acc && p; e_sq = acc && mis; e_mis = mis; e_err = err;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    longint et, eh;
`ifdef BIMODE_STATS_EN
    et = m_total; eh = m_hit;
`else
    et = 0; eh = 0;
`endif
    chk("pred_resp_valid", 64'(pred_resp_valid), 64'(e_rv));
    chk("prediction", 64'(prediction), 64'(e_pred));
    chk("pred_resp_squash", 64'(pred_resp_squash), 64'(e_sq));
    chk("upd_mispredict", 64'(upd_mispredict), 64'(e_mis));
    chk("upd_err", 64'(upd_err), 64'(e_err));
    chk("pred_ready", 64'(pred_ready), 64'(!m_recover && (m_q.size() < INFLIGHT)));
    chk("inflight_cnt", 64'(inflight_cnt), 64'(m_q.size()));
    chk("total_cnt", 64'(total_cnt), 64'(et));
    chk("hit_cnt", 64'(hit_cnt), 64'(eh));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    vectors++;
    #1;
    compare_all();
  endtask

  task automatic cyc(input bit v, input logic [63:0] a, input bit u, input bit r);
    pred_valid = v; branch_address = a; upd_valid = u; real_ton = r;
    step();
    pred_valid = 0; upd_valid = 0; real_ton = 0;
  endtask

  // Asynchronous reset between clock edges
  task automatic do_reset();
    rst = 1; pred_valid = 0; upd_valid = 0; real_ton = 0;
    #1;
    model_reset();
    compare_all();
    chk("rst_ready", 64'(pred_ready), 64'd1);
    chk("rst_inflight", 64'(inflight_cnt), 64'd0);
    chk("rst_resp_valid", 64'(pred_resp_valid), 64'd0);
    #1;
    rst = 0;
  endtask

  initial begin
    logic [63:0] a;
    bit v, u, r;
    branch_address = '0;
    do_reset();

    // Reset, predict 0x40 -> not taken, one in flight
    cyc(1, 64'h40, 0, 0);
    chk("s1_pred", 64'(prediction), 64'd0);
    chk("s1_valid", 64'(pred_resp_valid), 64'd1);
    chk("s1_squash", 64'(pred_resp_squash), 64'd0);
    chk("s1_inflight", 64'(inflight_cnt), 64'd1);

    // Mispredict trains chooser, then taken bank at index 0x41 predicts taken
    do_reset();
    cyc(1, 64'h100, 0, 0);
    chk("s2_pred0", 64'(prediction), 64'd0);
    cyc(0, 64'h0, 1, 1);
    chk("s2_mis", 64'(upd_mispredict), 64'd1);
    chk("s2_recover_ready", 64'(pred_ready), 64'd0);
    cyc(0, 64'h0, 0, 0);
    chk("s2_ready_back", 64'(pred_ready), 64'd1);
    cyc(1, 64'h100, 0, 0);
    chk("s2_pred1", 64'(prediction), 64'd1);
    cyc(0, 64'h0, 1, 1);
    chk("s2_hit_nomis", 64'(upd_mispredict), 64'd0);
`ifdef BIMODE_STATS_EN
    chk("s2_total", 64'(total_cnt), 64'd2);
    chk("s2_hit", 64'(hit_cnt), 64'd1);
`endif

    // Fill queue; a same-cycle resolve does not free the slot for the request
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, 64'(i * 4 + 64'h200), 0, 0);
    chk("s3_full_ready", 64'(pred_ready), 64'd0);
    chk("s3_full_cnt", 64'(inflight_cnt), 64'd4);
    cyc(1, 64'h300, 1, m_q[0].pred);
    chk("s3_not_accepted", 64'(pred_resp_valid), 64'd0);
    chk("s3_cnt", 64'(inflight_cnt), 64'd3);
    chk("s3_ready", 64'(pred_ready), 64'd1);

    // Three in flight, mispredict oldest -> flush, one-cycle RECOVER
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1, 64'(i * 4 + 64'h80), 0, 0);
    cyc(0, 64'h0, 1, !m_q[0].pred);
    chk("s4_cnt", 64'(inflight_cnt), 64'd0);
    chk("s4_ready", 64'(pred_ready), 64'd0);
    cyc(0, 64'h0, 0, 0);
    chk("s4_ready_back", 64'(pred_ready), 64'd1);
    cyc(1, 64'h84, 0, 0);

    // Predict in the same cycle as a mispredict -> squashed response
    do_reset();
    cyc(1, 64'h40, 0, 0);
    cyc(1, 64'h44, 1, !m_q[0].pred);
    chk("s5_squash", 64'(pred_resp_squash), 64'd1);
    chk("s5_valid", 64'(pred_resp_valid), 64'd1);
    chk("s5_cnt", 64'(inflight_cnt), 64'd0);
    cyc(0, 64'h0, 0, 0);
    cyc(0, 64'h0, 1, 0);
    chk("s5_err", 64'(upd_err), 64'd1);
`ifdef BIMODE_STATS_EN
    chk("s5_total", 64'(total_cnt), 64'd1);
`endif

    // Reset mid-stream with two in flight
    cyc(1, 64'h40, 0, 0);
    cyc(1, 64'h48, 0, 0);
    do_reset();
    cyc(1, 64'h40, 0, 0);
    chk("s6_pred", 64'(prediction), 64'd0);
    chk("s6_cnt", 64'(inflight_cnt), 64'd1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if (n % 1000 == 999) do_reset();
      a = {$urandom, $urandom};
      a[9:2] = {4'b0100, 4'($urandom_range(0, 15))};
      v = ($urandom_range(0, 3) != 0);
      u = ($urandom_range(0, 2) == 0);
      if (m_q.size() > 0 && $urandom_range(0, 9) < 7) r = m_q[0].pred;
      else r = 1'($urandom_range(0, 1));
      cyc(v, a, u, r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bimode_pred_ng.md
# bimode_pred_ng

Parametrised bi-mode branch predictor for the front-end predictor subsystem. It generalises the fixed-size bimode design with configurable address width, history length, table depth and counter width. It supports up to INFLIGHT speculative predictions outstanding, with a speculative global history, in-order resolution and mispredict recovery. Optional hit/total statistics replace testbench-side accuracy bookkeeping.

## Interface
- ADDR_W, 64: branch address width
- HIST_W, 8: global history length (bits)
- IDX_W, 8: index width; choice, taken and not-taken PHTs each have 2^IDX_W entries
- CNT_W, 2: saturating counter width (≥2)
- INFLIGHT, 4: max outstanding predictions (power of 2)
- STAT_W, 32: statistics counter width
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- pred_valid  in  1  prediction request
- pred_ready  out  1  request accepted when pred_valid && pred_ready
- branch_address  in  ADDR_W  address of branch to predict
- pred_resp_valid  out  1  response strobe
- prediction  out  1  predicted direction (1 = taken)
- pred_resp_squash  out  1  response belongs to a request killed by a same-cycle mispredict
- upd_valid  in  1  oldest in-flight branch resolved
- real_ton  in  1  actual outcome of oldest branch
- upd_mispredict  out  1  pulse: resolved outcome ≠ stored prediction
- upd_err  out  1  pulse: upd_valid with empty queue
- inflight_cnt  out  $clog2(INFLIGHT)+1  outstanding predictions
- total_cnt, hit_cnt  out  STAT_W  resolved / correctly predicted branches

## Operation
- Indices: base = branch_address[IDX_W+1:2]; choice_idx = base; dir_idx = base XOR spec_hist, zero-extended or truncated to IDX_W.
- Predict: the choice counter MSB selects the bank (1 = taken bank). prediction = MSB of the selected bank counter. On acceptance, push {choice_idx, dir_idx, bank_sel, prediction} into the queue. spec_hist <= {spec_hist[HIST_W-2:0], prediction}.
- Resolve (upd_valid, queue non-empty): pop the oldest entry and re-read the counters at its stored indices.
  - Selected bank counter saturates toward real_ton.
  - Choice counter saturates toward real_ton, except when bank_sel ≠ real_ton and the selected counter's MSB == real_ton.
  - arch_hist <= {arch_hist[HIST_W-2:0], real_ton}.
- Mispredict: flush the queue to empty, set spec_hist <= the new arch_hist value, and enter RECOVER.
- FSM states:
  - RUN: pred_ready = (inflight_cnt < INFLIGHT).
  - RECOVER: exactly 1 cycle, pred_ready = 0, then return to RUN.
- Counter reset values (CNT_W=2 shown):
  - choice: 2^(CNT_W-1)-1 (01, weakly not-taken)
  - taken bank: 2^(CNT_W-1) (10)
  - not-taken bank: 2^(CNT_W-1)-1 (01)
- Reset values: histories 0, queue empty, FSM RUN, all outputs 0 except pred_ready = 1.
- Boundaries:
  - Full queue: pred_ready = 0. A same-cycle resolve does not free the slot for that cycle's request.
  - upd_valid on empty queue: upd_err = 1 for one cycle; no state changes.
  - Predict and resolve in the same cycle: the predict reads pre-update tables (no bypass).
  - Predict in the same cycle as a mispredict resolve: the request is accepted but not enqueued; its response carries pred_resp_squash = 1; it causes no spec_hist update.
  - Pointers wrap modulo INFLIGHT.
  - Reset asserted mid-operation clears everything immediately.

## Timing
- Request accepted at edge N → pred_resp_valid, prediction, pred_resp_squash valid for exactly cycle N+1 (registered).
- Resolve sampled at edge N:
  - counter, history and queue updates are visible from N+1;
  - upd_mispredict and upd_err are registered and high during N+1;
  - after a mispredict, RECOVER occupies cycle N+1 and pred_ready is high again at N+2.
- inflight_cnt reflects pushes and pops of edge N during N+1.

## Configuration
- BIMODE_STATS_EN defined: total_cnt increments on every valid resolve and hit_cnt on every correct one. Both saturate at all-ones and reset to 0.
- BIMODE_STATS_EN undefined: no counters are instantiated; total_cnt and hit_cnt are tied to 0.

## Structure
- Package bimode_pkg holds:
  - the counter typedef;
  - reset-constant functions for the choice, taken and not-taken banks;
  - the saturating-increment/decrement function;
  - the in-flight entry struct;
  - the FSM state enum.
- Sub-module bimode_inflight_q is a parametrised circular FIFO with push, pop, flush, full, empty and count outputs.

## Test plan
- Reset, then predict 0x40 → response at N+1 with prediction=0, squash=0; inflight_cnt=1.
- Predict 0x100 and resolve taken (upd_mispredict=1). After RECOVER, predict 0x100 and resolve taken → prediction=1 (taken bank, idx 0x41); with stats enabled, total_cnt=2, hit_cnt=1.
- Four predicts without resolves → pred_ready=0. One correct resolve → pred_ready=1 the next cycle, inflight_cnt=3.
- Three in flight, mispredict on the oldest → inflight_cnt=0, pred_ready low one cycle, then spec_hist = arch_hist.
- Same-cycle predict and mispredict resolve → pred_resp_squash=1 and inflight_cnt=0. Separately, upd_valid on an empty queue → upd_err=1 with counters unchanged.
- Assert rst mid-stream with two in flight → outputs return to reset values immediately; next predict of 0x40 → prediction=0.
